// File: rtl/masked_xor_comar_vec.sv
// Two-share masked XOR/XNOR over WIDTH independent 1-bit lanes.
// Two-stage valid/ready pipeline; every stage load consumes fresh masks.
module masked_xor_comar_vec #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0]   b,
  input  logic [6*WIDTH-1:0]   r,
  input  logic                 op,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     out_count
);

  function automatic logic xor4(input logic w, input logic x, input logic y, input logic z);
    return w ^ x ^ y ^ z;
  endfunction

  logic             s1_valid_r, s1_op_r;
  logic [WIDTH-1:0] s1_a0_r, s1_a1_r, s1_b0_r, s1_b1_r;
  logic             s2_valid_r, s2_op_r;
  logic [WIDTH-1:0] s2_a0_r, s2_a1_r, s2_b0_r, s2_b1_r, s2_sum_r;
  logic [CNT_W-1:0] out_count_r;

  logic [WIDTH-1:0] s1_a0_s, s1_a1_s, s1_b0_s, s1_b1_s;
  logic [WIDTH-1:0] s2_a0_s, s2_a1_s, s2_b0_s, s2_b1_s, s2_sum_s;
  logic             s2_adv_s, in_fire_s;

  // Handshake control: S2 advances when empty or drained, S1 accepts when it can hand off.
  always_comb begin
    s2_adv_s  = !s2_valid_r || out_ready;
    in_ready  = !s1_valid_r || s2_adv_s;
    in_fire_s = in_valid && in_ready;
  end

  // Per-lane remasking; lane i only ever touches r[6i +: 6].
  always_comb begin
    s1_a0_s  = '0;
    s1_a1_s  = '0;
    s1_b0_s  = '0;
    s1_b1_s  = '0;
    s2_a0_s  = '0;
    s2_a1_s  = '0;
    s2_b0_s  = '0;
    s2_b1_s  = '0;
    s2_sum_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s1_a0_s[i]  = a[2*i]   ^ r[6*i];
      s1_a1_s[i]  = a[2*i+1] ^ r[6*i];
      s1_b0_s[i]  = b[2*i]   ^ r[6*i+1];
      s1_b1_s[i]  = b[2*i+1] ^ r[6*i+1];
      s2_a0_s[i]  = s1_a0_r[i] ^ r[6*i+2];
      s2_a1_s[i]  = s1_a1_r[i] ^ r[6*i+3];
      s2_b0_s[i]  = s1_b0_r[i] ^ r[6*i+4];
      s2_b1_s[i]  = s1_b1_r[i] ^ r[6*i+5];
      s2_sum_s[i] = xor4(r[6*i+2], r[6*i+3], r[6*i+4], r[6*i+5]);
    end
  end

  // Stage 1: load on input transfer, otherwise empty out when handing off to S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 1'b0;
      s1_a0_r    <= '0;
      s1_a1_r    <= '0;
      s1_b0_r    <= '0;
      s1_b1_r    <= '0;
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= op;
      s1_a0_r    <= s1_a0_s;
      s1_a1_r    <= s1_a1_s;
      s1_b0_r    <= s1_b0_s;
      s1_b1_r    <= s1_b1_s;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: on advance take S1 with fresh masks, or clear when S1 is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_op_r    <= 1'b0;
      s2_a0_r    <= '0;
      s2_a1_r    <= '0;
      s2_b0_r    <= '0;
      s2_b1_r    <= '0;
      s2_sum_r   <= '0;
    end else if (s2_adv_s) begin
      if (s1_valid_r) begin
        s2_valid_r <= 1'b1;
        s2_op_r    <= s1_op_r;
        s2_a0_r    <= s2_a0_s;
        s2_a1_r    <= s2_a1_s;
        s2_b0_r    <= s2_b0_s;
        s2_b1_r    <= s2_b1_s;
        s2_sum_r   <= s2_sum_s;
      end else begin
        s2_valid_r <= 1'b0;
        s2_op_r    <= 1'b0;
        s2_a0_r    <= '0;
        s2_a1_r    <= '0;
        s2_b0_r    <= '0;
        s2_b1_r    <= '0;
        s2_sum_r   <= '0;
      end
    end
  end

  // Completed-transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count_r <= '0;
    end else if (s2_valid_r && out_ready) begin
      out_count_r <= out_count_r + CNT_W'(1);
    end
  end

  // Output shares taken directly from S2 registers: share0 folds the remasked values, share1 is the mask sum.
  always_comb begin
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c[2*i]   = xor4(s2_a0_r[i], s2_a1_r[i], s2_b0_r[i], s2_b1_r[i]) ^ s2_op_r;
      c[2*i+1] = s2_sum_r[i];
    end
  end

  assign out_valid = s2_valid_r;
  assign out_count = out_count_r;

endmodule

// File: tb/tb_masked_xor_comar_vec.sv
// Directed self-checking bench for masked_xor_comar_vec (WIDTH=4, CNT_W=2).
module tb_masked_xor_comar_vec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  a, b, c;
  logic [23:0] r;
  logic        op, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  out_count;
  logic [23:0] rs1, rs2, rs3, rcur;
  logic [1:0]  wrap_exp [5];

  int n_vec = 0;
  int n_err = 0;

  masked_xor_comar_vec #(.WIDTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .r(r), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] share(input logic [3:0] v);
    logic [3:0] m;
    logic [7:0] s;
    m = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      s[2*i]   = v[i] ^ m[i];
      s[2*i+1] = m[i];
    end
    return s;
  endfunction

  function automatic logic [3:0] unmask(input logic [7:0] s);
    logic [3:0] u;
    for (int i = 0; i < 4; i++) u[i] = s[2*i] ^ s[2*i+1];
    return u;
  endfunction

  // Expected output shares: share1 = r2^r3^r4^r5 of the S2-load cycle, share0 = result ^ share1.
  function automatic logic [7:0] cexp(input logic [3:0] res, input logic [23:0] rv);
    logic [7:0] o;
    logic       s;
    for (int i = 0; i < 4; i++) begin
      s        = rv[6*i+2] ^ rv[6*i+3] ^ rv[6*i+4] ^ rv[6*i+5];
      o[2*i]   = res[i] ^ s;
      o[2*i+1] = s;
    end
    return o;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] av, input logic [3:0] bv, input logic opv);
    a = share(av);
    b = share(bv);
    op = opv;
    in_valid = 1'b1;
    r = 24'($urandom);
  endtask

  initial begin
    a = 8'h00; b = 8'h00; r = 24'h0; op = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_ov", 8'(out_valid), 8'h00);
    chk("rst_c", c, 8'h00);
    chk("rst_cnt", 8'(out_count), 8'h00);
    chk("rst_ir", 8'(in_ready), 8'h01);
    step; step;
    rst_n = 1'b1;

    // Single XOR: 1010 ^ 0110 = 1100
    offer(4'b1010, 4'b0110, 1'b0);
    step;
    chk("xor_lat1_ov", 8'(out_valid), 8'h00);
    in_valid = 1'b0; r = 24'($urandom); rs1 = r;
    step;
    chk("xor_ov", 8'(out_valid), 8'h01);
    chk("xor_c", c, cexp(4'b1100, rs1));
    chk("xor_unmask", 8'(unmask(c)), 8'h0C);
    step;
    chk("xor_ov_done", 8'(out_valid), 8'h00);
    chk("xor_cnt", 8'(out_count), 8'h01);

    // Back-to-back XOR then XNOR
    offer(4'b1010, 4'b0110, 1'b0);
    step;
    offer(4'b1010, 4'b0110, 1'b1); rs1 = r;
    chk("b2b_ir", 8'(in_ready), 8'h01);
    step;
    chk("b2b_ov0", 8'(out_valid), 8'h01);
    chk("b2b_c0", c, cexp(4'b1100, rs1));
    in_valid = 1'b0; r = 24'($urandom); rs2 = r;
    step;
    chk("b2b_ov1", 8'(out_valid), 8'h01);
    chk("xnor_c", c, cexp(4'b0011, rs2));
    chk("xnor_unmask", 8'(unmask(c)), 8'h03);
    chk("b2b_cnt2", 8'(out_count), 8'h02);
    step;
    chk("b2b_ov_done", 8'(out_valid), 8'h00);
    chk("b2b_cnt3", 8'(out_count), 8'h03);

    // Backpressure: two accepted, third held off
    out_ready = 1'b0;
    offer(4'b1010, 4'b0110, 1'b0);
    chk("bp_ir0", 8'(in_ready), 8'h01);
    step;
    offer(4'b1111, 4'b0001, 1'b0); rs1 = r;
    chk("bp_ir1", 8'(in_ready), 8'h01);
    step;
    offer(4'b0011, 4'b0101, 1'b1);
    chk("bp_ir2", 8'(in_ready), 8'h00);
    chk("bp_ov", 8'(out_valid), 8'h01);
    chk("bp_c", c, cexp(4'b1100, rs1));
    step;
    r = 24'($urandom);
    step;
    chk("bp_stall_c", c, cexp(4'b1100, rs1));
    chk("bp_stall_ir", 8'(in_ready), 8'h00);
    chk("bp_stall_cnt", 8'(out_count), 8'h03);
    out_ready = 1'b1; r = 24'($urandom); rs2 = r;
    #1;
    chk("bp_release_ir", 8'(in_ready), 8'h01);
    step;
    chk("bp_res2", c, cexp(4'b1110, rs2));
    chk("bp_cnt_wrap", 8'(out_count), 8'h00);
    in_valid = 1'b0; r = 24'($urandom); rs3 = r;
    step;
    chk("bp_res3", c, cexp(4'b1001, rs3));
    chk("bp_cnt1", 8'(out_count), 8'h01);
    step;
    chk("bp_ov_done", 8'(out_valid), 8'h00);
    chk("bp_cnt2", 8'(out_count), 8'h02);

    // Mid-stream reset with both stages full
    offer(4'b1010, 4'b0110, 1'b0);
    step;
    offer(4'b0101, 4'b0011, 1'b1);
    step;
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", 8'(out_valid), 8'h00);
    chk("mrst_c", c, 8'h00);
    chk("mrst_cnt", 8'(out_count), 8'h00);
    chk("mrst_ir", 8'(in_ready), 8'h01);
    in_valid = 1'b0;
    step; step;
    rst_n = 1'b1;

    // Counter wrap over 5 transfers; first input accepted on the first edge after reset
    for (int t = 1; t <= 7; t++) begin
      if (t <= 5) offer(4'b1100, 4'b1010, 1'b0);
      else in_valid = 1'b0;
      step;
      if (t == 2) chk("first_edge_ov", 8'(out_valid), 8'h01);
      if (t >= 3) chk("wrap_cnt", 8'(out_count), 8'(wrap_exp[t-3]));
    end

    // Masking sweep: fixed operands, fresh r every cycle, streaming at full rate
    a = share(4'b1001);
    b = share(4'b0011);
    op = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 1000; j++) begin
      r = 24'($urandom); rcur = r;
      step;
      if (j > 0) chk("mask_c", c, cexp(4'b1010, rcur));
    end
    in_valid = 1'b0; r = 24'($urandom); rcur = r;
    step;
    chk("mask_last", c, cexp(4'b1010, rcur));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
